// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the never-stalled pipeline write-back with a small FIFO of
// long-latency results onto the single register-file write port.
module wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_num,
    input  logic [31:0]   pipe_data,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [4:0]    lu_num,
    input  logic [31:0]   lu_data,
    input  logic          flush,
    output logic          WE,
    output logic [4:0]    W_num,
    output logic [31:0]   Din,
    output logic [31:0]   pend_mask,
    output logic [CW-1:0] q_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [DEPTH-1:0] slot_valid_q, slot_valid_d;
    logic [4:0]       slot_num_q  [DEPTH];
    logic [4:0]       slot_num_d  [DEPTH];
    logic [31:0]      slot_data_q [DEPTH];
    logic [31:0]      slot_data_d [DEPTH];

    logic        we_q, we_d;
    logic [4:0]  w_num_q, w_num_d;
    logic [31:0] din_q, din_d;

    logic pipe_wr;
    logic xfer;
    logic enq;
    logic pop;

    assign pipe_wr  = pipe_we && (pipe_num != 5'd0);
    assign lu_ready = (32'(count_q) < DEPTH);
    assign xfer     = lu_valid && lu_ready;
    assign enq      = xfer && !flush && (lu_num != 5'd0);
    assign pop      = !pipe_wr && (count_q != '0) && !flush;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        slot_valid_d = slot_valid_q;
        slot_num_d   = slot_num_q;
        slot_data_d  = slot_data_q;
        we_d         = 1'b0;
        w_num_d      = w_num_q;
        din_d        = din_q;

        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            slot_valid_d = '0;
        end else begin
            // A younger pipeline write to the same register makes queued results stale.
            if (pipe_wr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (slot_num_q[i] == pipe_num) begin
                        slot_valid_d[i] = 1'b0;
                    end
                end
            end
            if (pop) begin
                slot_valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d               = rd_ptr_q + 1'b1;
            end
            if (enq) begin
                slot_valid_d[wr_ptr_q] = !(pipe_wr && (lu_num == pipe_num));
                slot_num_d[wr_ptr_q]   = lu_num;
                slot_data_d[wr_ptr_q]  = lu_data;
                wr_ptr_d               = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(enq) - CW'(pop);
        end

        if (pipe_wr) begin
            we_d    = 1'b1;
            w_num_d = pipe_num;
            din_d   = pipe_data;
        end else if (pop && slot_valid_q[rd_ptr_q]) begin
            we_d    = 1'b1;
            w_num_d = slot_num_q[rd_ptr_q];
            din_d   = slot_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            slot_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_num_q[i]  <= '0;
                slot_data_q[i] <= '0;
            end
            we_q    <= 1'b0;
            w_num_q <= '0;
            din_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            slot_valid_q <= slot_valid_d;
            slot_num_q   <= slot_num_d;
            slot_data_q  <= slot_data_d;
            we_q         <= we_d;
            w_num_q      <= w_num_d;
            din_q        <= din_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid_q[i]) begin
                pend_mask[slot_num_q[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    assign WE      = we_q;
    assign W_num   = w_num_q;
    assign Din     = din_q;
    assign q_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected register-file writes are queued as stimulus
// is issued and a negedge monitor matches every WE pulse against them in order.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_num;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_num;
    logic [31:0] lu_data;
    logic        flush;
    logic        WE;
    logic [4:0]  W_num;
    logic [31:0] Din;
    logic [31:0] pend_mask;
    logic [2:0]  q_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q [$];

    wb_arbiter #(.DEPTH(4), .CW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe_we   (pipe_we),
        .pipe_num  (pipe_num),
        .pipe_data (pipe_data),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_num    (lu_num),
        .lu_data   (lu_data),
        .flush     (flush),
        .WE        (WE),
        .W_num     (W_num),
        .Din       (Din),
        .pend_mask (pend_mask),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    // Monitor: every write on the port must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && WE) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_port: unexpected write num=%0d data=%h, none expected",
                         W_num, Din);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({W_num, Din} !== e) begin
                    n_bad++;
                    $display("FAIL wr_port: got num=%0d data=%h, want num=%0d data=%h",
                             W_num, Din, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we  = 1'b0;
        pipe_num = '0;
        pipe_data = '0;
        lu_valid = 1'b0;
        lu_num   = '0;
        lu_data  = '0;
        flush    = 1'b0;
    endtask

    task automatic pipe(input logic [4:0] n, input logic [31:0] d);
        pipe_we   = 1'b1;
        pipe_num  = n;
        pipe_data = d;
        if (n != 5'd0) exp_q.push_back({n, d});
    endtask

    task automatic lu(input logic [4:0] n, input logic [31:0] d);
        lu_valid = 1'b1;
        lu_num   = n;
        lu_data  = d;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_wnum", 32'(W_num), 32'd0);
        chk("rst_din", Din, 32'd0);
        chk("rst_qcount", 32'(q_count), 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_ready", 32'(lu_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pipeline write, one cycle latency.
        @(posedge clk); #1;
        pipe(5'd5, 32'hDEADBEEF);
        step();
        idle_inputs();
        chk("pipe_we_lat", 32'(WE), 32'd1);
        step();
        chk("pipe_we_drop", 32'(WE), 32'd0);

        // Fill queue behind continuous pipeline writes, then drain in order.
        for (int k = 0; k < 4; k++) begin
            pipe(5'(k + 1), 32'h100 + 32'(k));
            lu(5'(k + 8), 32'h800 + 32'(k));
            step();
        end
        idle_inputs();
        chk("full_ready", 32'(lu_ready), 32'd0);
        chk("full_count", 32'(q_count), 32'd4);
        chk("full_pend", pend_mask, 32'h0000_0F00);
        for (int k = 0; k < 4; k++) exp_q.push_back({5'(k + 8), 32'h800 + 32'(k)});
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_we", 32'(WE), 32'd1);
        end
        chk("drain_count", 32'(q_count), 32'd0);
        chk("drain_pend", pend_mask, 32'd0);

        // WAW squash of a queued result.
        pipe(5'd3, 32'h33);
        lu(5'd7, 32'h11);
        step();
        idle_inputs();
        chk("sq_pend_set", pend_mask, 32'h0000_0080);
        pipe(5'd7, 32'h22);
        step();
        idle_inputs();
        chk("sq_pend_clr", pend_mask, 32'd0);
        chk("sq_count_hold", 32'(q_count), 32'd1);
        step();
        chk("sq_pop_idle", 32'(WE), 32'd0);
        chk("sq_count_pop", 32'(q_count), 32'd0);

        // Full queue with pop and a rejected offer in the same cycle.
        for (int k = 0; k < 4; k++) begin
            pipe(5'd1, 32'(k));
            lu(5'(k + 12), 32'hC00 + 32'(k));
            step();
        end
        idle_inputs();
        lu(5'd20, 32'h20);
        exp_q.push_back({5'd12, 32'hC00});
        step();
        idle_inputs();
        chk("fullpop_count", 32'(q_count), 32'd3);
        chk("fullpop_ready", 32'(lu_ready), 32'd1);
        for (int k = 1; k < 4; k++) exp_q.push_back({5'(k + 12), 32'hC00 + 32'(k)});
        step(); step(); step();
        chk("fullpop_drain", 32'(q_count), 32'd0);

        // Flush with same-cycle transfer and pipeline write.
        for (int k = 0; k < 3; k++) begin
            pipe(5'd1, 32'hF0 + 32'(k));
            lu(5'(k + 16), 32'hA00 + 32'(k));
            step();
        end
        idle_inputs();
        chk("preflush_count", 32'(q_count), 32'd3);
        flush = 1'b1;
        lu(5'd19, 32'hBAD);
        pipe(5'd2, 32'h2222);
        step();
        idle_inputs();
        chk("flush_count", 32'(q_count), 32'd0);
        chk("flush_pend", pend_mask, 32'd0);
        chk("flush_we", 32'(WE), 32'd1);
        chk("flush_wnum", 32'(W_num), 32'd2);
        step();
        chk("flush_idle", 32'(WE), 32'd0);

        // Register 0 is never written from either source.
        pipe(5'd0, 32'h1234);
        lu(5'd0, 32'h5678);
        step();
        idle_inputs();
        chk("r0_we", 32'(WE), 32'd0);
        chk("r0_count", 32'(q_count), 32'd0);
        step();
        chk("r0_we2", 32'(WE), 32'd0);

        // Asynchronous reset mid-operation.
        pipe(5'd1, 32'h71);
        lu(5'd21, 32'h21);
        step();
        pipe(5'd1, 32'h72);
        lu(5'd22, 32'h22);
        step();
        @(negedge clk); #1;
        chk("pre_rst_count", 32'(q_count), 32'd2);
        chk("pre_rst_we", 32'(WE), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(WE), 32'd0);
        chk("arst_wnum", 32'(W_num), 32'd0);
        chk("arst_count", 32'(q_count), 32'd0);
        chk("arst_pend", pend_mask, 32'd0);
        chk("arst_ready", 32'(lu_ready), 32'd1);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
